icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 The block SHALL have parameter MEM_SCALE, default 27, word-address width of the refill port.
REQ-002 The block SHALL have parameter LINE_LOG, default 2, log2 of words per DRAM line (line = 32<<LINE_LOG bits).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 super_oe  in  1  single-cycle refill request pulse from the instruction cache.
REQ-007 super_addr  in  MEM_SCALE  word address of the request, valid while super_oe=1.
REQ-008 super_rdata  out  32  returned instruction word.
REQ-009 super_valid  out  1  one-cycle pulse, super_rdata valid.
REQ-010 clear  in  1  invalidate the line buffer.
REQ-011 dram_oe  out  1  DRAM line-read request, held until accepted.
REQ-012 dram_addr  out  MEM_SCALE-LINE_LOG  line address.
REQ-013 dram_ready  in  1  DRAM accepts the request when dram_oe&&dram_ready.
REQ-014 dram_rdata  in  32<<LINE_LOG  returned line; word i at bits [32*i +: 32].
REQ-015 dram_valid  in  1  dram_rdata valid, one cycle.
REQ-016 lb_cnt_req  out  32  accepted refill requests.
REQ-017 lb_cnt_hit  out  32  requests served from the line buffer.

Function
REQ-018 The block SHALL hold one line buffer: valid bit, tag (super_addr[MEM_SCALE-1:LINE_LOG]), line data.
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, RESP; super_oe is accepted only in IDLE and SHALL be ignored (not queued, not counted) in any other state.
REQ-020 On acceptance the block SHALL latch super_addr; the latched value drives dram_addr and word select.
REQ-021 Hit (buffer valid, tag match, clear=0 that cycle): stay IDLE, assert super_valid with the selected buffer word exactly 1 cycle after super_oe.
REQ-022 Miss: IDLE->REQ; in REQ dram_oe=1 with dram_addr stable until dram_ready=1, then ->WAIT.
REQ-023 In WAIT on dram_valid=1 the block SHALL capture the line, set tag and valid, ->RESP; in RESP super_valid=1 for one cycle with word super_addr[LINE_LOG-1:0] of the captured line, ->IDLE.
REQ-024 Minimum miss latency SHALL be 3 cycles from super_oe to super_valid (dram_ready and dram_valid each at first opportunity).
REQ-025 super_rdata SHALL hold its value between super_valid pulses.
REQ-026 dram_valid outside WAIT SHALL be ignored; dram_ready outside REQ SHALL be ignored; dram_oe SHALL be 0 outside REQ.
REQ-027 clear SHALL invalidate the buffer at the next edge; clear and super_oe in the same cycle SHALL be handled as a miss.
REQ-028 clear during REQ/WAIT/RESP: the pending line SHALL still be returned to the requester but SHALL NOT be stored (buffer remains invalid).
REQ-029 lb_cnt_req SHALL increment on each accepted super_oe; lb_cnt_hit on each accepted hit; both wrap modulo 2^32.

Reset
REQ-030 While rst_n=0: state IDLE, buffer invalid, super_valid=0, super_rdata=0, dram_oe=0, dram_addr=0, counters=0.
REQ-031 Reset mid-operation SHALL abandon the transaction; a dram_valid arriving after release SHALL be ignored (state IDLE).

Verification
REQ-032 Cold miss: reset, super_oe addr=0x40, dram_ready=1, dram_valid 1 cycle later with line {w3..w0}={0xD,0xC,0xB,0xA} -> dram_addr=0x10, super_valid 3 cycles after super_oe, super_rdata=0xA, counters req=1 hit=0.
REQ-033 Hit: then super_oe addr=0x43 -> super_valid next cycle, super_rdata=0xD, no dram_oe, req=2 hit=1.
REQ-034 Backpressure: miss at addr=0x80 with dram_ready low 5 cycles -> dram_oe high and dram_addr=0x20 stable all 6 cycles, single handshake.
REQ-035 Clear: clear during WAIT, then super_oe addr=0x81 -> first response correct, second is a miss (dram_oe reasserted).
REQ-036 Busy/reset: super_oe during REQ ignored (req count unchanged); rst_n low in WAIT, late dram_valid after release -> no super_valid, all outputs 0.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: single-line buffer in front of a line-wide DRAM port.
// Hits are answered from the buffer in one cycle; misses fetch a whole line over a req/ready + valid handshake.
module icache_refill #(
    parameter int unsigned MEM_SCALE = 27,
    parameter int unsigned LINE_LOG  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           super_oe,
    input  logic [MEM_SCALE-1:0]           super_addr,
    output logic [31:0]                    super_rdata,
    output logic                           super_valid,
    input  logic                           clear,
    output logic                           dram_oe,
    output logic [MEM_SCALE-LINE_LOG-1:0]  dram_addr,
    input  logic                           dram_ready,
    input  logic [(32<<LINE_LOG)-1:0]      dram_rdata,
    input  logic                           dram_valid,
    output logic [31:0]                    lb_cnt_req,
    output logic [31:0]                    lb_cnt_hit
);

    localparam int unsigned TAG_W  = MEM_SCALE - LINE_LOG;
    localparam int unsigned WORDS  = 1 << LINE_LOG;
    localparam int unsigned LINE_W = 32 << LINE_LOG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [MEM_SCALE-1:0]   addr_q;
    logic                   lb_valid_q;
    logic [TAG_W-1:0]       lb_tag_q;
    logic [LINE_W-1:0]      lb_data_q;
    logic                   drop_q;
    logic                   dram_oe_q;
    logic                   super_valid_q;
    logic [31:0]            super_rdata_q;
    logic [31:0]            cnt_req_q;
    logic [31:0]            cnt_hit_q;

    logic                   accept;
    logic                   hit;
    logic                   capture;
    logic [31:0]            hit_word;
    logic [31:0]            fill_word;

    // Word select out of a line by the low address bits.
    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                              input logic [LINE_LOG-1:0] sel);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            if (sel == LINE_LOG'(i)) begin
                w = line[32*i +: 32];
            end
        end
        return w;
    endfunction

    assign hit_word  = pick_word(lb_data_q, super_addr[LINE_LOG-1:0]);
    assign fill_word = pick_word(dram_rdata, addr_q[LINE_LOG-1:0]);

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        hit     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (super_oe) begin
                    accept = 1'b1;
                    if (lb_valid_q && !clear && (lb_tag_q == super_addr[MEM_SCALE-1:LINE_LOG])) begin
                        hit = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dram_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dram_valid) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, DRAM request, response and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            dram_oe_q     <= 1'b0;
            super_valid_q <= 1'b0;
            super_rdata_q <= 32'd0;
            cnt_req_q     <= 32'd0;
            cnt_hit_q     <= 32'd0;
        end else begin
            if (accept) begin
                addr_q    <= super_addr;
                cnt_req_q <= cnt_req_q + 32'd1;
            end
            if (hit) begin
                cnt_hit_q <= cnt_hit_q + 32'd1;
            end
            dram_oe_q     <= (state_d == REQ);
            super_valid_q <= hit | capture;
            if (hit) begin
                super_rdata_q <= hit_word;
            end else if (capture) begin
                super_rdata_q <= fill_word;
            end
        end
    end

    // Line buffer; a clear seen while a fetch is in flight keeps that line out of the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            if (accept) begin
                drop_q <= 1'b0;
            end else if (clear) begin
                drop_q <= 1'b1;
            end
            if (clear) begin
                lb_valid_q <= 1'b0;
            end else if (capture && !drop_q) begin
                lb_valid_q <= 1'b1;
            end
            if (capture) begin
                lb_tag_q  <= addr_q[MEM_SCALE-1:LINE_LOG];
                lb_data_q <= dram_rdata;
            end
        end
    end

    assign dram_oe     = dram_oe_q;
    assign dram_addr   = addr_q[MEM_SCALE-1:LINE_LOG];
    assign super_valid = super_valid_q;
    assign super_rdata = super_rdata_q;
    assign lb_cnt_req  = cnt_req_q;
    assign lb_cnt_hit  = cnt_hit_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: cold miss, hit, backpressure, busy drop, clear and mid-fetch reset.
module tb_icache_refill;

    localparam int unsigned MEM_SCALE = 27;
    localparam int unsigned LINE_LOG  = 2;

    logic                          clk;
    logic                          rst_n;
    logic                          super_oe;
    logic [MEM_SCALE-1:0]          super_addr;
    logic [31:0]                   super_rdata;
    logic                          super_valid;
    logic                          clear;
    logic                          dram_oe;
    logic [MEM_SCALE-LINE_LOG-1:0] dram_addr;
    logic                          dram_ready;
    logic [127:0]                  dram_rdata;
    logic                          dram_valid;
    logic [31:0]                   lb_cnt_req;
    logic [31:0]                   lb_cnt_hit;

    int n_chk;
    int n_fail;

    icache_refill #(.MEM_SCALE(MEM_SCALE), .LINE_LOG(LINE_LOG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .super_oe    (super_oe),
        .super_addr  (super_addr),
        .super_rdata (super_rdata),
        .super_valid (super_valid),
        .clear       (clear),
        .dram_oe     (dram_oe),
        .dram_addr   (dram_addr),
        .dram_ready  (dram_ready),
        .dram_rdata  (dram_rdata),
        .dram_valid  (dram_valid),
        .lb_cnt_req  (lb_cnt_req),
        .lb_cnt_hit  (lb_cnt_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        super_oe   = 1'b0;
        super_addr = '0;
        clear      = 1'b0;
        dram_ready = 1'b0;
        dram_rdata = '0;
        dram_valid = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(super_valid), 32'd0);
        check("rst_rdata", super_rdata, 32'd0);
        check("rst_dram_oe", 32'(dram_oe), 32'd0);
        check("rst_dram_addr", 32'(dram_addr), 32'd0);
        check("rst_cnt_req", lb_cnt_req, 32'd0);
        check("rst_cnt_hit", lb_cnt_hit, 32'd0);
        rst_n = 1'b1;
        tick();

        // Cold miss at 0x40.
        super_oe   = 1'b1;
        super_addr = 27'h40;
        tick();
        super_oe = 1'b0;
        check("cold_dram_oe", 32'(dram_oe), 32'd1);
        check("cold_dram_addr", 32'(dram_addr), 32'h10);
        check("cold_valid_c1", 32'(super_valid), 32'd0);
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        check("cold_oe_drop", 32'(dram_oe), 32'd0);
        check("cold_valid_c2", 32'(super_valid), 32'd0);
        dram_valid = 1'b1;
        dram_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        tick();
        dram_valid = 1'b0;
        check("cold_valid_c3", 32'(super_valid), 32'd1);
        check("cold_rdata", super_rdata, 32'hA);
        check("cold_cnt_req", lb_cnt_req, 32'd1);
        check("cold_cnt_hit", lb_cnt_hit, 32'd0);
        tick();
        check("cold_valid_pulse", 32'(super_valid), 32'd0);
        check("cold_rdata_hold", super_rdata, 32'hA);

        // Hit at 0x43, word 3.
        super_oe   = 1'b1;
        super_addr = 27'h43;
        tick();
        super_oe = 1'b0;
        check("hit_valid", 32'(super_valid), 32'd1);
        check("hit_rdata", super_rdata, 32'hD);
        check("hit_no_dram", 32'(dram_oe), 32'd0);
        check("hit_cnt_req", lb_cnt_req, 32'd2);
        check("hit_cnt_hit", lb_cnt_hit, 32'd1);
        tick();

        // Miss at 0x80 with 5 cycles of backpressure; a hit-address request mid-wait is dropped.
        super_oe   = 1'b1;
        super_addr = 27'h80;
        tick();
        super_oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_oe", 32'(dram_oe), 32'd1);
            check("bp_addr", 32'(dram_addr), 32'h20);
            check("bp_no_valid", 32'(super_valid), 32'd0);
            if (i == 2) begin
                super_oe   = 1'b1;
                super_addr = 27'h43;
            end else begin
                super_oe   = 1'b0;
                super_addr = 27'h80;
            end
            tick();
        end
        super_oe = 1'b0;
        check("bp_busy_cnt_req", lb_cnt_req, 32'd3);
        check("bp_busy_cnt_hit", lb_cnt_hit, 32'd1);
        check("bp_oe_c6", 32'(dram_oe), 32'd1);
        check("bp_addr_c6", 32'(dram_addr), 32'h20);
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        check("bp_single_hs", 32'(dram_oe), 32'd0);

        // Clear while waiting: line still returned but not kept.
        clear = 1'b1;
        tick();
        clear      = 1'b0;
        dram_valid = 1'b1;
        dram_rdata = {32'h24, 32'h23, 32'h22, 32'h21};
        tick();
        dram_valid = 1'b0;
        check("clr_valid", 32'(super_valid), 32'd1);
        check("clr_rdata", super_rdata, 32'h21);
        tick();
        super_oe   = 1'b1;
        super_addr = 27'h81;
        tick();
        super_oe = 1'b0;
        check("clr_remiss_oe", 32'(dram_oe), 32'd1);
        check("clr_remiss_valid", 32'(super_valid), 32'd0);
        check("clr_cnt_req", lb_cnt_req, 32'd4);
        check("clr_cnt_hit", lb_cnt_hit, 32'd1);
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        dram_valid = 1'b1;
        dram_rdata = {32'h34, 32'h33, 32'h32, 32'h31};
        tick();
        dram_valid = 1'b0;
        check("refill_rdata", super_rdata, 32'h32);
        tick();

        // Clear together with a request to a resident line is a miss.
        super_oe   = 1'b1;
        super_addr = 27'h82;
        clear      = 1'b1;
        tick();
        super_oe = 1'b0;
        clear    = 1'b0;
        check("clr_same_oe", 32'(dram_oe), 32'd1);
        check("clr_same_valid", 32'(super_valid), 32'd0);
        check("clr_same_hit", lb_cnt_hit, 32'd1);

        // Reset in WAIT, then a late dram_valid after release.
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("mid_rst_oe", 32'(dram_oe), 32'd0);
        check("mid_rst_cnt", lb_cnt_req, 32'd0);
        tick();
        rst_n      = 1'b1;
        dram_valid = 1'b1;
        tick();
        dram_valid = 1'b0;
        check("late_valid", 32'(super_valid), 32'd0);
        check("late_rdata", super_rdata, 32'd0);
        check("late_oe", 32'(dram_oe), 32'd0);
        check("late_addr", 32'(dram_addr), 32'd0);
        check("late_cnt_hit", lb_cnt_hit, 32'd0);
        super_oe   = 1'b1;
        super_addr = 27'h82;
        tick();
        super_oe = 1'b0;
        check("post_rst_miss", 32'(dram_oe), 32'd1);
        check("post_rst_cnt", lb_cnt_req, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
